bus_scheduler: RTL

Generates the CPU phase clock (`s_phi_x`, `s_phi_extend`) that feeds `micro` and time-multiplexes the shared 16 KB DRAM between the 6502 and the video bitmap fetcher. Each 8-clock CPU cycle provides one video slot and one CPU slot. If the video fetcher is starved, the scheduler stretches phi_0 high to open an extra video slot. It also implements the frame-counting watchdog that resets the CPU when software stops servicing it.

---
 rtl/mc_bus_pkg.sv | 28 ++
 rtl/bus_scheduler_watchdog.sv | 90 +++++++++
 rtl/bus_scheduler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_bus_pkg.sv
// mc_bus_pkg: shared types and constants for the DRAM bus scheduler.
// Holds the scheduler state encoding, the phase numbers of the slots inside
// an 8-clock CPU cycle, the extension length and a small saturating helper.
package mc_bus_pkg;

  // Scheduler states: normal 8-phase rotation, or phi_0 stretched at phase 3.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    EXTEND = 1'b1
  } sched_state_e;

  // Phase numbers inside one CPU cycle.
  localparam logic [2:0] PH_VID = 3'd1;  // video DRAM slot
  localparam logic [2:0] PH_EXT = 3'd3;  // extension decision / hold phase
  localparam logic [2:0] PH_CPU = 3'd5;  // CPU DRAM slot
  localparam logic [2:0] PH_END = 3'd7;  // end of cycle, starvation bookkeeping

  // Extension length in clocks and the derived extension-counter constants.
  localparam int unsigned EXT_LEN  = 4;
  localparam logic [1:0]  EXT_LAST = 2'(EXT_LEN - 1);
  localparam logic [1:0]  EXT_VID  = 2'd1;  // extension step that carries the video slot

  // Two-bit saturating increment for the starvation counter.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : (v + 2'd1);
  endfunction

endpackage

// File: rtl/bus_scheduler_watchdog.sv
// watchdog: frame-counting CPU watchdog.
// Counts rising edges of (vcnt_i == 0). wd_clear_i zeroes the count and wins
// over a simultaneous frame edge. When WD_FRAMES edges accumulate, the count
// clears and wd_reset_o is driven high for WD_PULSE clocks; a clear during
// the pulse does not shorten it.
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   vcnt_i      vertical count, frame boundary when it becomes 0
//   wd_clear_i  one-clock service strobe
//   wd_reset_o  registered CPU reset pulse
module watchdog #(
  parameter int unsigned WD_FRAMES = 8,
  parameter int unsigned WD_PULSE  = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] vcnt_i,
  input  logic       wd_clear_i,
  output logic       wd_reset_o
);

  localparam int unsigned   CW         = $clog2(WD_FRAMES + 1);
  localparam int unsigned   PW         = (WD_PULSE > 1) ? $clog2(WD_PULSE) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(WD_FRAMES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(WD_PULSE - 1);

  logic          zero_q, zero_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          pulse_q, pulse_d;
  logic          frame_edge;
  logic          fire;

  // Frame edge detect, frame counter and pulse stretcher next-state.
  always_comb begin
    zero_d     = (vcnt_i == 8'd0);
    frame_edge = zero_d & ~zero_q;
    cnt_d      = cnt_q;
    fire       = 1'b0;
    pcnt_d     = pcnt_q;
    pulse_d    = pulse_q;

    if (wd_clear_i) begin
      cnt_d = {CW{1'b0}};
    end else if (frame_edge) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = {CW{1'b0}};
        fire  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    // pcnt holds the number of high clocks still owed after the current one.
    if (fire) begin
      pulse_d = 1'b1;
      pcnt_d  = PULSE_LAST;
    end else if (pulse_q) begin
      if (pcnt_q == {PW{1'b0}}) begin
        pulse_d = 1'b0;
      end else begin
        pcnt_d = pcnt_q - PW'(1);
      end
    end else begin
      pulse_d = 1'b0;
    end
  end

  // Watchdog state registers. zero_q resets high so a vcnt of 0 present at
  // reset release is not counted as a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zero_q  <= 1'b1;
      cnt_q   <= {CW{1'b0}};
      pcnt_q  <= {PW{1'b0}};
      pulse_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign wd_reset_o = pulse_q;

endmodule

// File: rtl/bus_scheduler.sv
// bus_scheduler: CPU phase clock generator and DRAM arbiter.
// An 8-clock CPU cycle (phase ph 0..7) carries a video slot at ph 1 and a CPU
// slot at ph 5. A video requester starved for STARVE_LIMIT cycles causes a
// 4-clock stretch of phi_0 at ph 3 that carries an extra video slot.
// Ports:
//   clk_10M, reset            clock, asynchronous active-high reset
//   vcnt, wd_clear            watchdog inputs (frame count, service strobe)
//   cpu_addr, cpu_rw          CPU bus request (cpu_rw = 1 read)
//   vid_req, vid_addr         video fetch request and address
//   s_phi_x, s_phi_extend     phase clock outputs
//   ram_cs, ram_we, ram_addr  DRAM control
//   cpu_ram_sel               DRAM slot owned by the CPU
//   vid_ack                   one-clock video grant
//   wd_reset                  watchdog CPU reset pulse
// All outputs are registered; each output register is loaded with the value
// belonging to the phase being entered, so outputs line up with ph_q.
module bus_scheduler
  import mc_bus_pkg::*;
#(
  parameter logic [15:0] RAM_TOP      = 16'h4000,
  parameter int unsigned STARVE_LIMIT = 2,  // 0..3, starve counter is 2 bits
  parameter int unsigned WD_FRAMES    = 8,
  parameter int unsigned WD_PULSE     = 16
) (
  input  logic        clk_10M,
  input  logic        reset,
  input  logic [7:0]  vcnt,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  input  logic        wd_clear,
  output logic        s_phi_x,
  output logic        s_phi_extend,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [13:0] ram_addr,
  output logic        cpu_ram_sel,
  output logic        vid_ack,
  output logic        wd_reset
);

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_LIMIT);

  sched_state_e state_q, state_d;
  logic [2:0]   ph_q, ph_d;
  logic [1:0]   ext_q, ext_d;
  logic [1:0]   starve_q, starve_d;
  logic         ack_seen_q, ack_seen_d;
  logic         phi_x_q, phi_x_d;
  logic         phi_ext_q, phi_ext_d;
  logic         ram_cs_q, ram_cs_d;
  logic         ram_we_q, ram_we_d;
  logic [13:0]  ram_addr_q, ram_addr_d;
  logic         cpu_sel_q, cpu_sel_d;
  logic         vid_ack_q, vid_ack_d;

  // Phase sequencing, slot decode for the phase being entered, starvation.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    ext_d      = ext_q;
    starve_d   = starve_q;
    ack_seen_d = ack_seen_q;
    phi_x_d    = 1'b0;
    phi_ext_d  = 1'b0;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    cpu_sel_d  = 1'b0;
    vid_ack_d  = 1'b0;

    case (state_q)
      RUN: begin
        if ((ph_q == PH_EXT) && vid_req && (starve_q >= STARVE_LIM)) begin
          state_d = EXTEND;  // ph stays at PH_EXT for the whole stretch
          ext_d   = 2'd0;
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      EXTEND: begin
        if (ext_q == EXT_LAST) begin
          state_d = RUN;
          ph_d    = PH_EXT + 3'd1;
          ext_d   = 2'd0;
        end else begin
          ext_d = ext_q + 2'd1;
        end
      end
      default: begin
        state_d = RUN;
        ph_d    = PH_END;
        ext_d   = 2'd0;
      end
    endcase

    if (state_d == EXTEND) begin
      // phi_x low and extend high keeps the combined phi_0 high.
      phi_ext_d = 1'b1;
      if ((ext_d == EXT_VID) && vid_req) begin
        ram_cs_d   = 1'b1;
        ram_addr_d = vid_addr;
        vid_ack_d  = 1'b1;
      end else begin
        vid_ack_d = 1'b0;
      end
    end else begin
      phi_x_d = ~ph_d[2];  // high for ph 0..3
      case (ph_d)
        PH_VID: begin
          if (vid_req) begin
            ram_cs_d   = 1'b1;
            ram_addr_d = vid_addr;
            vid_ack_d  = 1'b1;
          end else begin
            vid_ack_d = 1'b0;
          end
        end
        PH_CPU: begin
          if (cpu_addr < RAM_TOP) begin
            ram_cs_d   = 1'b1;
            cpu_sel_d  = 1'b1;
            ram_addr_d = cpu_addr[13:0];
            ram_we_d   = ~cpu_rw;
          end else if (vid_req) begin
            // CPU is off-DRAM: the slot goes to a pending video fetch.
            ram_cs_d   = 1'b1;
            ram_addr_d = vid_addr;
            vid_ack_d  = 1'b1;
          end else begin
            ram_cs_d = 1'b0;
          end
        end
        default: begin
          ram_cs_d = 1'b0;
        end
      endcase
    end

    // ack_seen remembers a grant earlier in this cycle so a request that was
    // served and then re-raised is not counted as starved at ph 7.
    if (vid_ack_q) begin
      starve_d   = 2'd0;
      ack_seen_d = 1'b1;
    end else if ((state_q == RUN) && (ph_q == PH_END)) begin
      if (vid_req && !ack_seen_q) begin
        starve_d = sat_inc2(starve_q);
      end else begin
        starve_d = starve_q;
      end
      ack_seen_d = 1'b0;
    end else begin
      starve_d = starve_q;
    end
  end

  // Scheduler state and registered outputs; reset aborts any extension.
  always_ff @(posedge clk_10M or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      ph_q       <= PH_END;
      ext_q      <= 2'd0;
      starve_q   <= 2'd0;
      ack_seen_q <= 1'b0;
      phi_x_q    <= 1'b0;
      phi_ext_q  <= 1'b0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= 14'd0;
      cpu_sel_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      ext_q      <= ext_d;
      starve_q   <= starve_d;
      ack_seen_q <= ack_seen_d;
      phi_x_q    <= phi_x_d;
      phi_ext_q  <= phi_ext_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      cpu_sel_q  <= cpu_sel_d;
      vid_ack_q  <= vid_ack_d;
    end
  end

  watchdog #(
    .WD_FRAMES (WD_FRAMES),
    .WD_PULSE  (WD_PULSE)
  ) u_watchdog (
    .clk_i      (clk_10M),
    .rst_i      (reset),
    .vcnt_i     (vcnt),
    .wd_clear_i (wd_clear),
    .wd_reset_o (wd_reset)
  );

  assign s_phi_x      = phi_x_q;
  assign s_phi_extend = phi_ext_q;
  assign ram_cs       = ram_cs_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign cpu_ram_sel  = cpu_sel_q;
  assign vid_ack      = vid_ack_q;

endmodule
